seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Iterative radix-2 shift-add multiplier; successor to the team's single-cycle combinational multiplier.
- Generalised over WIDTH and adds:
  - a per-operation signed/unsigned mode
  - a full 2*WIDTH product, plus a truncated WIDTH-bit result with overflow flag
  - valid/ready handshakes on input and output
- Used in datapaths where a WIDTH x WIDTH array multiplier is too large or too slow for the clock target.

Parameters:
- WIDTH, 8, operand width in bits; legal range >= 2.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operands a, b and is_signed are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  output  1  result outputs are valid.
- out_ready  input  1  downstream accepts result.
- p  output  2*WIDTH  full product.
- y  output  WIDTH  low WIDTH bits of p.
- ovf  output  1  p is not representable in WIDTH bits under the selected mode.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state -> IDLE; p=0, y=0, ovf=0, out_valid=0, in_ready=1; internal counter and registers cleared.
  - Reset wins over every other event, including mid-operation; any in-flight operation is discarded with no output.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1, out_valid=0. An accept edge (in_valid && in_ready) latches a, b, is_signed.
    - Signed mode: records sign = a[MSB]^b[MSB] and replaces each operand by its magnitude (WIDTH-bit unsigned; the most-negative value maps to 2^(WIDTH-1)).
    - Clears the accumulator and counter, then -> BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle: if the current multiplier LSB is 1, the shifted multiplicand is added to the 2*WIDTH accumulator; the multiplier shifts right, the multiplicand shifts left, and the counter increments.
    - After exactly WIDTH iterations, the accumulator is two's-negated if sign=1 (signed mode), registered to p/y/ovf, and the FSM goes to DONE.
  - DONE: out_valid=1, in_ready=0; p, y and ovf hold stable.
    - On an edge with out_ready=1 -> IDLE, out_valid falls and in_ready rises on the next cycle.
    - out_ready may be held high permanently.
- Latency:
  - Fixed and data-independent, with no early termination on zero operands.
  - out_valid rises on the (WIDTH+1)th rising edge after the accept edge.
  - Throughput is one operation per WIDTH+2 cycles when out_ready=1.
- Input handshake:
  - in_valid with in_ready=0 is ignored; no queueing.
  - Operand changes after the accept edge have no effect.
  - in_valid is not required to stay high after acceptance.
- Arithmetic:
  - Unsigned: p = a*b exactly. Signed: p = a*b as a 2*WIDTH two's-complement value.
  - y = p[WIDTH-1:0] in both modes.
  - ovf, unsigned: p[2*WIDTH-1:WIDTH] != 0.
  - ovf, signed: p[2*WIDTH-1:WIDTH-1] is neither all zeros nor all ones.
  - Multiplication by zero gives p=0 in both modes, including signed with a negative operand, so a negated zero stays 0.
- Outputs p, y and ovf hold their last result values in IDLE and BUSY. They are only meaningful while out_valid=1.

Test Plan:
- Reset then idle, WIDTH=8: hold rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, p=0, y=0, ovf=0.
- Unsigned max, WIDTH=8, is_signed=0: a=8'hFF, b=8'hFF -> out_valid rises 9 edges after accept; p=16'hFE01, y=8'h01, ovf=1.
- Signed cases, WIDTH=8:
  - a=-3 (8'hFD), b=5 -> p=16'hFFF1 (-15), y=8'hF1, ovf=0.
  - a=-128 (8'h80), b=-128 -> p=16'h4000, ovf=1.
  - a=0, b=-7 -> p=0, ovf=0.
- Backpressure and ignored input: out_ready=0 for 5 cycles after out_valid -> p, y and ovf stable, in_ready=0. A new in_valid pulse during BUSY/DONE is not accepted. Raising out_ready -> IDLE next cycle, then the next operation is accepted.
- Reset mid-operation: assert rst_n=0 on the 4th BUSY cycle -> next cycle state IDLE, out_valid=0, p=0. The following operation a=7, b=6 unsigned gives p=42, ovf=0.
- Back-to-back with out_ready=1: three operations presented with in_valid held high -> results appear in order, spaced 10 cycles apart; repeat a random regression at WIDTH=4 and WIDTH=16 against a reference model.

Source files
------------

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
//               with per-operation signed/unsigned mode and valid/ready
//               handshakes on both sides. One operation takes WIDTH BUSY
//               cycles; results are held in DONE until out_ready.
// Ports       :
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   a, b, is_signed valid          in_ready  operation can be accepted
//   a, b       multiplicand / multiplier      is_signed 1 = two's complement
//   out_valid  p, y, ovf valid                out_ready downstream accepts result
//   p          full 2*WIDTH product           y         low WIDTH bits of p
//   ovf        p not representable in WIDTH bits under the selected mode
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic [WIDTH-1:0]     y,
    output logic                 ovf
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Counter value during the final iteration; the result is registered on
    // that same edge so DONE follows exactly WIDTH BUSY cycles.
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]           r_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_sign;
    logic                 r_signed;
    logic [2*WIDTH-1:0]   r_p;
    logic                 r_ovf;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_sum;
    logic [2*WIDTH-1:0]   w_final;
    logic [WIDTH:0]       w_top;
    logic                 w_ovf;

    // Magnitudes in signed mode. The most-negative value negates to itself,
    // which read as unsigned is exactly 2^(WIDTH-1), the correct magnitude.
    assign w_mag_a = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign w_mag_b = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_sum    = r_acc + w_addend;

    // Negating a zero accumulator yields zero, so x*0 stays 0 in signed mode.
    assign w_final  = r_sign ? (~w_sum + (2 * WIDTH)'(1)) : w_sum;

    // Signed result fits in WIDTH bits when the upper WIDTH+1 bits are a pure
    // sign extension (all zeros or all ones).
    assign w_top = w_final[2*WIDTH-1:WIDTH-1];
    assign w_ovf = r_signed ? !((&w_top) || !(|w_top))
                            : (|w_final[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_signed <= 1'b0;
            r_p      <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_sign   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_signed <= is_signed;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_p     <= w_final;
                        r_ovf   <= w_ovf;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign p         = r_p;
    assign y         = r_p[WIDTH-1:0];
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier at WIDTH 8, 4 and 16.
//               Expected results come from an integer reference model or from
//               literal values and are queued when an operation is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv8, ir8, s8, ov8, or8, f8;
    logic [7:0]  a8, b8, y8;
    logic [15:0] p8;

    logic        iv4, ir4, s4, ov4, or4, f4;
    logic [3:0]  a4, b4, y4;
    logic [7:0]  p4;

    logic        iv16, ir16, s16, ov16, or16, f16;
    logic [15:0] a16, b16, y16;
    logic [31:0] p16;

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .is_signed(s8), .out_valid(ov8), .out_ready(or8), .p(p8), .y(y8), .ovf(f8));

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .is_signed(s4), .out_valid(ov4), .out_ready(or4), .p(p4), .y(y4), .ovf(f4));

    seq_multiplier #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .is_signed(s16), .out_valid(ov16), .out_ready(or16), .p(p16), .y(y16), .ovf(f16));

    typedef struct {
        longint p;
        bit     ovf;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t q16[$];

    int n_vec = 0;
    int n_err = 0;

    // Integer reference: sign-extend operands, multiply, mask to 2*w bits.
    function automatic exp_t model(int w, longint a, longint b, bit s);
        longint ai = a;
        longint bi = b;
        longint prod;
        exp_t   e;
        if (s && a[w-1]) ai = a - (longint'(1) << w);
        if (s && b[w-1]) bi = b - (longint'(1) << w);
        prod  = ai * bi;
        e.p   = prod & ((longint'(1) << (2 * w)) - 1);
        if (s) e.ovf = (prod < -(longint'(1) << (w - 1))) || (prod >= (longint'(1) << (w - 1)));
        else   e.ovf = (prod >= (longint'(1) << w));
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one WIDTH=8 operation, waits for acceptance, queues its
    // expected result and scrambles the operands to show they are not reused.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit s);
        int guard = 0;
        a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
        while (ir8 !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (ir8 !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL issue8_timeout: in_ready=%b required 1", ir8);
        end
        tick();
        q8.push_back(model(8, longint'(a), longint'(b), s));
        iv8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5; s8 = ~s;
    endtask

    task automatic wait_valid8(output int edges);
        edges = 0;
        while (ov8 !== 1'b1 && edges < 60) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++; if (ir8 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", ir8); end
        n_vec++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", ov8); end
        n_vec++; if (p8 !== 16'h0) begin n_err++; $display("FAIL reset_p: got %h want 0000", p8); end
        n_vec++; if (y8 !== 8'h0) begin n_err++; $display("FAIL reset_y: got %h want 00", y8); end
        n_vec++; if (f8 !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", f8); end
        n_vec++; if (ir4 !== 1'b1 || ir16 !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready_w4_w16: got %b/%b want 1/1", ir4, ir16);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unsigned_max;
        int   edges;
        exp_t e;
        or8 = 1'b0;
        issue8(8'hFF, 8'hFF, 1'b0);
        wait_valid8(edges);
        // Counting the accept edge as the first, out_valid is up on edge 9,
        // i.e. 8 further edges after the accept edge.
        n_vec++; if (ov8 !== 1'b1 || edges != 8) begin
            n_err++; $display("FAIL umax_latency: out_valid=%b after %0d edges, want 1 after 8", ov8, edges);
        end
        e = q8.pop_front();
        n_vec++; if (p8 !== 16'hFE01) begin n_err++; $display("FAIL umax_p: got %h want fe01", p8); end
        n_vec++; if (y8 !== 8'h01) begin n_err++; $display("FAIL umax_y: got %h want 01", y8); end
        n_vec++; if (f8 !== 1'b1 || e.ovf !== 1'b1) begin
            n_err++; $display("FAIL umax_ovf: got %b want 1", f8);
        end
        or8 = 1'b1; tick(); or8 = 1'b0;
    endtask

    task automatic test_signed;
        logic [7:0]  ta [3] = '{8'hFD, 8'h80, 8'h00};
        logic [7:0]  tb [3] = '{8'h05, 8'h80, 8'hF9};
        logic [15:0] tp [3] = '{16'hFFF1, 16'h4000, 16'h0000};
        logic        tf [3] = '{1'b0, 1'b1, 1'b0};
        int   edges;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            or8 = 1'b0;
            issue8(ta[i], tb[i], 1'b1);
            wait_valid8(edges);
            e = q8.pop_front();
            n_vec++; if (ov8 !== 1'b1 || p8 !== tp[i] || 16'(e.p) !== tp[i]) begin
                n_err++; $display("FAIL signed_p[%0d]: got %h (valid=%b) want %h", i, p8, ov8, tp[i]);
            end
            n_vec++; if (y8 !== tp[i][7:0]) begin
                n_err++; $display("FAIL signed_y[%0d]: got %h want %h", i, y8, tp[i][7:0]);
            end
            n_vec++; if (f8 !== tf[i]) begin
                n_err++; $display("FAIL signed_ovf[%0d]: got %b want %b", i, f8, tf[i]);
            end
            or8 = 1'b1; tick(); or8 = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        int   edges;
        exp_t e;
        or8 = 1'b0;
        issue8(8'h9C, 8'h37, 1'b0);
        // Stray operation request while BUSY must not be taken.
        a8 = 8'h11; b8 = 8'h22; iv8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (ir8 !== 1'b0) begin n_err++; $display("FAIL busy_in_ready[%0d]: got %b want 0", i, ir8); end
            tick();
        end
        iv8 = 1'b0;
        wait_valid8(edges);
        n_vec++; if (ov8 !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", ov8); end
        e = q8.pop_front();
        for (int i = 0; i < 5; i++) begin
            iv8 = (i % 2 == 0);
            n_vec++; if (ov8 !== 1'b1 || ir8 !== 1'b0 || p8 !== 16'(e.p) || y8 !== 8'(e.p) || f8 !== e.ovf) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b p=%h y=%h ovf=%b want 1 0 %h %h %b",
                         i, ov8, ir8, p8, y8, f8, 16'(e.p), 8'(e.p), e.ovf);
            end
            tick();
        end
        iv8 = 1'b0;
        or8 = 1'b1; tick(); or8 = 1'b0;
        n_vec++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            n_err++; $display("FAIL bp_release: ready=%b valid=%b want 1 0", ir8, ov8);
        end
        issue8(8'h12, 8'h34, 1'b0);
        wait_valid8(edges);
        e = q8.pop_front();
        n_vec++; if (ov8 !== 1'b1 || p8 !== 16'(e.p) || f8 !== e.ovf) begin
            n_err++; $display("FAIL bp_next: valid=%b p=%h ovf=%b want 1 %h %b", ov8, p8, f8, 16'(e.p), e.ovf);
        end
        or8 = 1'b1; tick(); or8 = 1'b0;
        // No phantom result from the ignored requests.
        for (int i = 0; i < 12; i++) tick();
        n_vec++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL bp_no_extra: valid=%b want 0", ov8); end
    endtask

    task automatic test_reset_mid;
        int   edges;
        exp_t e;
        or8 = 1'b0;
        issue8(8'hAB, 8'hCD, 1'b1);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        n_vec++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
            n_err++; $display("FAIL midrst_state: valid=%b ready=%b want 0 1", ov8, ir8);
        end
        n_vec++; if (p8 !== 16'h0 || y8 !== 8'h0 || f8 !== 1'b0) begin
            n_err++; $display("FAIL midrst_outputs: p=%h y=%h ovf=%b want 0000 00 0", p8, y8, f8);
        end
        rst_n = 1'b1;
        void'(q8.pop_back());
        issue8(8'd7, 8'd6, 1'b0);
        wait_valid8(edges);
        e = q8.pop_front();
        n_vec++; if (ov8 !== 1'b1 || p8 !== 16'd42 || f8 !== 1'b0 || 16'(e.p) !== 16'd42) begin
            n_err++; $display("FAIL midrst_next: valid=%b p=%0d ovf=%b want 1 42 0", ov8, p8, f8);
        end
        or8 = 1'b1; tick(); or8 = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] oa [3] = '{8'd3, 8'hF0, 8'd100};
        logic [7:0] ob [3] = '{8'd4, 8'h10, 8'd2};
        bit         os [3] = '{1'b0, 1'b1, 1'b0};
        int   idx = 0, got = 0, last = 0, cyc = 0;
        bit   acc;
        exp_t e;
        or8 = 1'b1;
        a8 = oa[0]; b8 = ob[0]; s8 = os[0]; iv8 = 1'b1;
        while (got < 3 && cyc < 200) begin
            acc = (ir8 === 1'b1) && (iv8 === 1'b1);
            if (ov8 === 1'b1) begin
                e = q8.pop_front();
                n_vec++; if (p8 !== 16'(e.p) || f8 !== e.ovf) begin
                    n_err++; $display("FAIL b2b_result[%0d]: p=%h ovf=%b want %h %b", got, p8, f8, 16'(e.p), e.ovf);
                end
                if (got > 0) begin
                    n_vec++; if (cyc - last != 10) begin
                        n_err++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 10", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                q8.push_back(model(8, longint'(oa[idx]), longint'(ob[idx]), os[idx]));
                idx++;
                if (idx < 3) begin a8 = oa[idx]; b8 = ob[idx]; s8 = os[idx]; end
                else iv8 = 1'b0;
            end
        end
        n_vec++; if (got != 3) begin n_err++; $display("FAIL b2b_timeout: got %0d results want 3", got); end
        or8 = 1'b0; iv8 = 1'b0;
    endtask

    task automatic test_random_w4;
        int   issued = 0, got = 0, cyc = 0;
        bit   acc;
        exp_t e;
        or4 = 1'b1;
        a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom); iv4 = 1'b1;
        while (got < 24 && cyc < 1000) begin
            acc = (ir4 === 1'b1) && (iv4 === 1'b1);
            if (ov4 === 1'b1) begin
                e = q4.pop_front();
                n_vec++; if (p4 !== 8'(e.p) || y4 !== 4'(e.p) || f4 !== e.ovf) begin
                    n_err++; $display("FAIL w4_result[%0d]: p=%h y=%h ovf=%b want %h %h %b",
                                      got, p4, y4, f4, 8'(e.p), 4'(e.p), e.ovf);
                end
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                q4.push_back(model(4, longint'(a4), longint'(b4), s4));
                issued++;
                a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
                if (issued >= 24) iv4 = 1'b0;
            end
        end
        n_vec++; if (got != 24) begin n_err++; $display("FAIL w4_timeout: got %0d results want 24", got); end
        iv4 = 1'b0;
    endtask

    task automatic test_random_w16;
        int   issued = 0, got = 0, cyc = 0;
        bit   acc;
        exp_t e;
        or16 = 1'b1;
        a16 = 16'h8000; b16 = 16'h8000; s16 = 1'b1; iv16 = 1'b1;
        while (got < 24 && cyc < 2000) begin
            acc = (ir16 === 1'b1) && (iv16 === 1'b1);
            if (ov16 === 1'b1) begin
                e = q16.pop_front();
                n_vec++; if (p16 !== 32'(e.p) || y16 !== 16'(e.p) || f16 !== e.ovf) begin
                    n_err++; $display("FAIL w16_result[%0d]: p=%h y=%h ovf=%b want %h %h %b",
                                      got, p16, y16, f16, 32'(e.p), 16'(e.p), e.ovf);
                end
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                q16.push_back(model(16, longint'(a16), longint'(b16), s16));
                issued++;
                a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
                if (issued % 5 == 1) b16 = 16'($urandom_range(0, 3));
                if (issued >= 24) iv16 = 1'b0;
            end
        end
        n_vec++; if (got != 24) begin n_err++; $display("FAIL w16_timeout: got %0d results want 24", got); end
        iv16 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        iv8 = 1'b0;  or8 = 1'b0;  a8 = '0;  b8 = '0;  s8 = 1'b0;
        iv4 = 1'b0;  or4 = 1'b0;  a4 = '0;  b4 = '0;  s4 = 1'b0;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random_w4();
        test_random_w16();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
